// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_ctrl
// Description : Run/halt/single-step sequencer for the 8-bit CPU. Gates the
//               control unit's register/PC write enables, produces a clock
//               enable that freezes the control FSM, and keeps saturating
//               cycle and retired-instruction counters.
//               The optional PC breakpoint is built when BREAKPOINT_EN is
//               defined. Without it the breakpoint ports are accepted but
//               ignored, and the BREAK state is never entered.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_run_req/i_halt_req/i_step_req - single-cycle requests
//               i_pc                - current PC from datapath
//               i_reg_we_in/i_pc_we_in - write enables from control
//                                       (i_pc_we_in marks final cycle)
//               i_bp_addr/i_bp_set/i_bp_clr - breakpoint load/clear
//               i_cnt_clr           - clear both counters
//               o_reg_we_out/o_pc_we_out - gated write enables
//               o_cpu_en            - control FSM clock enable
//               o_state             - 00 HALT, 01 RUN, 10 STEP, 11 BREAK
//               o_halted            - state is HALT or BREAK
//               o_cycle_count/o_instr_count - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int PC_N  = 6,
    parameter int CNT_N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run_req,
    input  logic             i_halt_req,
    input  logic             i_step_req,
    input  logic [PC_N-1:0]  i_pc,
    input  logic             i_reg_we_in,
    input  logic             i_pc_we_in,
    input  logic [PC_N-1:0]  i_bp_addr,
    input  logic             i_bp_set,
    input  logic             i_bp_clr,
    input  logic             i_cnt_clr,
    output logic             o_reg_we_out,
    output logic             o_pc_we_out,
    output logic             o_cpu_en,
    output logic [1:0]       o_state,
    output logic             o_halted,
    output logic [CNT_N-1:0] o_cycle_count,
    output logic [CNT_N-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [CNT_N-1:0] c_cnt_max = '1;
    localparam logic [CNT_N-1:0] c_cnt_one = {{(CNT_N-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_at_fetch;
    logic             w_bp_hit;
    logic             w_cpu_en;
    logic             w_boundary;
    logic [CNT_N-1:0] r_cycle_count;
    logic [CNT_N-1:0] r_instr_count;

    assign w_cpu_en   = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_bp_hit;
    // The last micro-cycle of an instruction, actually executed.
    assign w_boundary = i_pc_we_in && w_cpu_en;

`ifdef BREAKPOINT_EN
    logic            r_bp_valid;
    logic [PC_N-1:0] r_bp_addr;
    logic            r_skip_bp;
    logic            w_leave_break;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_valid <= 1'b0;
            r_bp_addr  <= '0;
        end else if (i_bp_clr) begin
            r_bp_valid <= 1'b0;
        end else if (i_bp_set) begin
            r_bp_valid <= 1'b1;
            r_bp_addr  <= i_bp_addr;
        end
    end

    // Resuming from BREAK must let the instruction sitting at the breakpoint
    // retire once, otherwise it would re-break immediately on the same fetch.
    assign w_leave_break = (r_state == ST_BREAK) && !i_halt_req &&
                           (i_run_req || i_step_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_bp <= 1'b0;
        end else if (w_leave_break) begin
            r_skip_bp <= 1'b1;
        end else if (w_boundary) begin
            r_skip_bp <= 1'b0;
        end
    end

    assign w_bp_hit = (r_state == ST_RUN) && r_at_fetch && r_bp_valid &&
                      (i_pc == r_bp_addr) && !r_skip_bp;
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{i_bp_addr, i_bp_set, i_bp_clr, i_pc, r_at_fetch};
    assign w_bp_hit    = 1'b0;
`endif

    // AtFetch is only touched on enabled cycles, so it survives a halt that
    // lands mid-instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_at_fetch <= 1'b1;
        end else if (w_boundary) begin
            r_at_fetch <= 1'b1;
        end else if (w_cpu_en) begin
            r_at_fetch <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HALT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HALT: begin
                // A simultaneous halt request suppresses run/step.
                if (!i_halt_req) begin
                    if (i_run_req)       w_state_nxt = ST_RUN;
                    else if (i_step_req) w_state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt_req)    w_state_nxt = ST_HALT;
                else if (w_bp_hit) w_state_nxt = ST_BREAK;
            end
            ST_STEP: begin
                if (i_halt_req || w_boundary) w_state_nxt = ST_HALT;
            end
            ST_BREAK: begin
                if (i_halt_req)      w_state_nxt = ST_HALT;
                else if (i_run_req)  w_state_nxt = ST_RUN;
                else if (i_step_req) w_state_nxt = ST_STEP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || i_cnt_clr) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (w_cpu_en && (r_cycle_count != c_cnt_max)) begin
                r_cycle_count <= r_cycle_count + c_cnt_one;
            end
            if (w_boundary && (r_instr_count != c_cnt_max)) begin
                r_instr_count <= r_instr_count + c_cnt_one;
            end
        end
    end

    assign o_reg_we_out  = i_reg_we_in && w_cpu_en;
    assign o_pc_we_out   = i_pc_we_in && w_cpu_en;
    assign o_cpu_en      = w_cpu_en;
    assign o_state       = r_state;
    assign o_halted      = (r_state == ST_HALT) || (r_state == ST_BREAK);
    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_run_ctrl
// Description : Self-checking bench for cpu_run_ctrl. A small control-unit
//               emulator produces instructions of 1-4 micro-cycles; a
//               behavioural model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int PC_N  = 6;
    localparam int CNT_N = 4;
    localparam int CMAX  = (1 << CNT_N) - 1;
`ifdef BREAKPOINT_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             run_req, halt_req, step_req;
    logic [PC_N-1:0]  pc, bp_addr;
    logic             reg_we_in, pc_we_in, bp_set, bp_clr, cnt_clr;
    logic             reg_we_out, pc_we_out, cpu_en, halted;
    logic [1:0]       state;
    logic [CNT_N-1:0] cycle_count, instr_count;

    cpu_run_ctrl #(.PC_N(PC_N), .CNT_N(CNT_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_run_req    (run_req),
        .i_halt_req   (halt_req),
        .i_step_req   (step_req),
        .i_pc         (pc),
        .i_reg_we_in  (reg_we_in),
        .i_pc_we_in   (pc_we_in),
        .i_bp_addr    (bp_addr),
        .i_bp_set     (bp_set),
        .i_bp_clr     (bp_clr),
        .i_cnt_clr    (cnt_clr),
        .o_reg_we_out (reg_we_out),
        .o_pc_we_out  (pc_we_out),
        .o_cpu_en     (cpu_en),
        .o_state      (state),
        .o_halted     (halted),
        .o_cycle_count(cycle_count),
        .o_instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 halted, 1 running, 2 stepping, 3 stopped at breakpoint.
    int m_mode = 0;
    bit m_known = 1'b0;
    bit m_atf, m_skip, m_bpv;
    int m_bpa, m_cyc, m_ins;
    bit e_hit, e_en, e_bnd;

    // Control-unit emulator.
    int cu_mc = 0, cu_len = 3, cu_pc = 0, fix_len = 3;

    int en_seen = 0, brk_seen = 0;
    bit pwo_seen = 1'b0;

    task automatic drive_ctrl();
        pc_we_in  = (cu_mc == cu_len - 1);
        pc        = cu_pc[PC_N-1:0];
        reg_we_in = 1'($urandom_range(0, 1));
    endtask

    task automatic model_comb();
        e_hit = BP_EN && (m_mode == 1) && m_atf && m_bpv && (int'(pc) == m_bpa) && !m_skip;
        e_en  = ((m_mode == 1) || (m_mode == 2)) && !e_hit;
        e_bnd = pc_we_in && e_en;
    endtask

    task automatic model_update();
        int nm;
        if (rst) begin
            m_known = 1'b1;
            m_mode = 0; m_atf = 1'b1; m_skip = 1'b0; m_bpv = 1'b0;
            m_bpa = 0; m_cyc = 0; m_ins = 0;
        end else begin
            nm = m_mode;
            if (m_mode == 0) begin
                if (!halt_req && run_req)                   nm = 1;
                else if (!halt_req && step_req)             nm = 2;
            end else if (m_mode == 1) begin
                if (halt_req)                               nm = 0;
                else if (e_hit)                             nm = 3;
            end else if (m_mode == 2) begin
                if (halt_req || e_bnd)                      nm = 0;
            end else begin
                if (halt_req)                               nm = 0;
                else if (run_req)                           nm = 1;
                else if (step_req)                          nm = 2;
            end
            if (m_mode == 3 && (nm == 1 || nm == 2)) m_skip = 1'b1;
            else if (e_bnd)                          m_skip = 1'b0;
            if (e_bnd)     m_atf = 1'b1;
            else if (e_en) m_atf = 1'b0;
            if (bp_clr) m_bpv = 1'b0;
            else if (bp_set) begin m_bpv = 1'b1; m_bpa = int'(bp_addr); end
            if (cnt_clr) begin
                m_cyc = 0; m_ins = 0;
            end else begin
                if (e_en && m_cyc < CMAX)  m_cyc++;
                if (e_bnd && m_ins < CMAX) m_ins++;
            end
            m_mode = nm;
        end
    endtask

    task automatic ctrl_update();
        if (rst) begin
            cu_mc = 0;
            cu_len = (fix_len != 0) ? fix_len : int'($urandom_range(1, 4));
        end else if (e_en) begin
            if (pc_we_in) begin
                cu_mc = 0;
                if (fix_len != 0) begin
                    cu_len = fix_len;
                    cu_pc  = (cu_pc + 1) % 16;
                end else begin
                    cu_len = int'($urandom_range(1, 4));
                    cu_pc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                         : (cu_pc + 1) % 16;
                end
            end else begin
                cu_mc++;
            end
        end
    endtask

    task automatic tick();
        drive_ctrl();
        @(negedge clk);
        model_comb();
        en_seen += int'(cpu_en);
        pwo_seen = pwo_seen | pc_we_out;
        if (state == 2'b11) brk_seen++;
        if (m_known) begin
            chk("state",      32'(state),       32'(m_mode));
            chk("halted",     32'(halted),      32'(m_mode == 0 || m_mode == 3));
            chk("cpu_en",     32'(cpu_en),      32'(e_en));
            chk("reg_we_out", 32'(reg_we_out),  32'(reg_we_in && e_en));
            chk("pc_we_out",  32'(pc_we_out),   32'(e_bnd));
            chk("cycle_cnt",  32'(cycle_count), 32'(m_cyc));
            chk("instr_cnt",  32'(instr_count), 32'(m_ins));
        end
        @(posedge clk);
        model_update();
        ctrl_update();
        #1;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_set = 1'b0; bp_clr = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_set = 1'b0; bp_clr = 1'b0; cnt_clr = 1'b0; bp_addr = '0;
        pc = '0; reg_we_in = 1'b0; pc_we_in = 1'b0;
        #1;

        // Reset for two cycles.
        tick(); tick();
        rst = 1'b0;
        chk("rst_state",  32'(state),       32'd0);
        chk("rst_halted", 32'(halted),      32'd1);
        chk("rst_cpu_en", 32'(cpu_en),      32'd0);
        chk("rst_cycle",  32'(cycle_count), 32'd0);
        chk("rst_instr",  32'(instr_count), 32'd0);

        // Single step over a 3-cycle instruction.
        step_req = 1'b1; tick();
        en_seen = 0;
        repeat (6) tick();
        chk("step_en_cycles", 32'(en_seen),     32'd3);
        chk("step_state",     32'(state),       32'd0);
        chk("step_instr",     32'(instr_count), 32'd1);
        chk("step_cycle",     32'(cycle_count), 32'd3);

        // Halt in the 2nd micro-cycle, resume 5 cycles later.
        run_req = 1'b1; tick();
        tick();
        halt_req = 1'b1; tick();
        en_seen = 0;
        repeat (5) tick();
        chk("halt_frozen", 32'(en_seen), 32'd0);
        run_req = 1'b1; tick();
        pwo_seen = 1'b0;
        tick();
        chk("resume_pcwe", 32'(pwo_seen), 32'd1);
        halt_req = 1'b1; tick();

        // All three requests together while halted.
        halt_req = 1'b1; run_req = 1'b1; step_req = 1'b1; tick();
        chk("simul_req_state", 32'(state), 32'd0);

        // Counter saturation and clear-over-increment.
        cnt_clr = 1'b1; tick();
        run_req = 1'b1; tick();
        repeat (20) tick();
        chk("cyc_sat", 32'(cycle_count), 32'd15);
        cnt_clr = 1'b1; tick();
        chk("cyc_clr", 32'(cycle_count), 32'd0);
        halt_req = 1'b1; tick();

`ifdef BREAKPOINT_EN
        // Break at PC 5, then resume past it.
        fix_len = 2; cu_pc = 0; cu_mc = 0; cu_len = 2;
        bp_set = 1'b1; bp_addr = 6'h05; tick();
        run_req = 1'b1; tick();
        for (int i = 0; i < 60 && m_mode != 3; i++) tick();
        chk("bp_reach", 32'(state), 32'd3);
        run_req = 1'b1; tick();
        pwo_seen = 1'b0;
        for (int i = 0; i < 10 && !pwo_seen; i++) tick();
        chk("bp_retire",     32'(pwo_seen), 32'd1);
        chk("bp_no_rebreak", 32'(state),    32'd1);
        halt_req = 1'b1; tick();

        // Set and clear together leaves the breakpoint invalid.
        bp_set = 1'b1; bp_clr = 1'b1; bp_addr = 6'h05; tick();
        cu_pc = 0; cu_mc = 0; cu_len = 2;
        run_req = 1'b1; tick();
        brk_seen = 0;
        repeat (30) tick();
        chk("bp_setclr", 32'(brk_seen), 32'd0);
        halt_req = 1'b1; tick();
`endif

        // Randomized traffic against the model.
        fix_len = 0;
        for (int i = 0; i < 1500; i++) begin
            run_req  = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 23) == 0);
            step_req = ($urandom_range(0, 15) == 0);
            bp_set   = ($urandom_range(0, 19) == 0);
            bp_clr   = ($urandom_range(0, 39) == 0);
            cnt_clr  = ($urandom_range(0, 29) == 0);
            bp_addr  = PC_N'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt/single-step sequencer for the 8-bit CPU. It sits between the control unit and the datapath and gates their write enables. It also produces a clock-enable that freezes the control FSM, and provides a PC breakpoint plus cycle and instruction counters. It lets the board or bench halt, step and resume program execution without disturbing register or PC state.

Parameters:
pc_n, 6, program counter / RAM address width
cnt_n, 16, width of the cycle and instruction counters

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
RunReq  input  1  single-cycle pulse: start/resume free-running execution
HaltReq  input  1  single-cycle pulse: stop execution
StepReq  input  1  single-cycle pulse: execute exactly one instruction
Pc  input  pc_n  current PC from datapath
RegWeIn  input  1  register write enable from control
PcWeIn  input  1  PC write enable from control; marks the instruction's final cycle
BpAddr  input  pc_n  breakpoint address
BpSet  input  1  load BpAddr into breakpoint register, mark valid
BpClr  input  1  invalidate breakpoint
CntClr  input  1  clear both counters
RegWeOut  output  1  gated register write enable to datapath
PcWeOut  output  1  gated PC write enable to datapath
CpuEn  output  1  clock-enable for the control FSM
State  output  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
Halted  output  1  high when State is HALT or BREAK
CycleCount  output  cnt_n  enabled-cycle count
InstrCount  output  cnt_n  retired-instruction count

Behaviour:
- Reset:
  - State=HALT, Halted=1, CpuEn=0, RegWeOut=0, PcWeOut=0.
  - CycleCount=0, InstrCount=0.
  - Breakpoint invalid, AtFetch=1, SkipBp=0.
- Gating (combinational, zero latency):
  - RegWeOut = RegWeIn & CpuEn.
  - PcWeOut = PcWeIn & CpuEn.
- CpuEn = (State==RUN | State==STEP) & ~BpHit.
- Boundary = PcWeIn & CpuEn.
- AtFetch register:
  - Set on reset and on each Boundary.
  - Cleared on any other CpuEn=1 cycle.
- BpHit (combinational) = State==RUN & AtFetch & BpValid & (Pc==BpAddr_reg) & ~SkipBp.
  - Breakpoints are evaluated only in RUN.
  - When BpHit, no write enable passes that cycle.
- SkipBp:
  - Set when leaving BREAK via RunReq or StepReq.
  - Cleared on the first Boundary after that.
  - This lets execution resume past the breakpointed instruction.
- Request priority when asserted in the same cycle: HaltReq > RunReq > StepReq.
- Transitions, all registered, effective next cycle:
  - HALT: RunReq->RUN; StepReq->STEP; else stay.
  - RUN: HaltReq->HALT; BpHit->BREAK; else stay. RunReq and StepReq are ignored.
  - STEP: HaltReq->HALT; Boundary->HALT; else stay. Exactly one instruction retires per StepReq.
  - BREAK: HaltReq->HALT; RunReq->RUN; StepReq->STEP; else stay.
- Mid-instruction halt:
  - Control FSM is frozen via CpuEn, so its state is retained.
  - A later RUN or STEP resumes at the same micro-cycle.
  - AtFetch is unchanged across the halt.
- Breakpoint register:
  - BpSet loads BpAddr and sets valid.
  - BpClr clears valid. BpClr wins over a simultaneous BpSet.
  - Changes take effect on the next cycle's compare.
- Counters:
  - CycleCount += 1 on each CpuEn=1 cycle.
  - InstrCount += 1 on each Boundary.
  - Both saturate at 2^cnt_n-1 and do not wrap.
  - CntClr zeroes both; it wins over a simultaneous increment.
- Reset mid-operation overrides everything and returns all state to reset values.

Optional Feature:
BREAKPOINT_EN.
- Defined: breakpoint register, BpHit logic, SkipBp and the BREAK state are implemented as above.
- Undefined:
  - BpAddr, BpSet and BpClr remain as ports but are ignored.
  - BpHit is constant 0 and State never reaches 11.
  - SkipBp logic is omitted. Port list is identical in both builds.

Test Plan:
- Reset asserted 2 cycles, then released -> State=00, Halted=1, CpuEn=0, both counters 0; RegWeIn=PcWeIn=1 gives RegWeOut=PcWeOut=0.
- From HALT, StepReq pulse; control drives a 3-cycle instruction with PcWeIn in cycle 3 -> CpuEn high exactly 3 cycles, State back to 00, InstrCount=1, CycleCount=3.
- RunReq, then HaltReq in the 2nd cycle of an instruction -> CpuEn drops next cycle. A RunReq 5 cycles later resumes; PcWeOut asserts after exactly 1 more enabled cycle.
- BREAKPOINT_EN, BpSet with BpAddr=6'h05, RunReq; program reaches Pc=05 at fetch -> State=11, CpuEn=0 in that cycle, no write enables. RunReq -> instruction at 05 retires, next fetch at 05 is not re-broken.
- Same cycle HaltReq+RunReq+StepReq in HALT -> State stays 00. BpSet+BpClr together -> breakpoint invalid, Pc=BpAddr does not break.
- With cnt_n=4, run 20 enabled cycles -> CycleCount=15, saturated. CntClr together with an enabled cycle -> CycleCount=0.
